// File: rtl/audio_rd_burst_fifo_pkg.sv
// Shared constants and types for the audio read burst FIFO.
// Optional features used by the top: AUDIO_RD_ZERO_FILL_EN, SIM_ENABLE.
package audio_rd_burst_fifo_pkg;

  localparam int unsigned MEM_RD_BL = 16;  // words per memory read burst
  localparam int unsigned DSIZE_DEF = 36;  // memory data width
  localparam int unsigned PCM_DSIZE = 16;  // PCM sample width
  localparam int unsigned WORD_W    = 32;  // used part of a memory word

  // Burst request FSM encodings
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } burst_state_t;

  // One stored memory word: two PCM samples, low half played first
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } pcm_pair_t;

endpackage

// File: rtl/sfifo_fwft_w32.sv
// Single-clock FWFT FIFO of 32-bit words with an occupancy count.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   wr_en, wr_data   push (ignored while full)
//   rd_en            pop of the head word (ignored while empty)
//   count            registered occupancy, 0..DEPTH
//   count_nxt_c      occupancy after this cycle's push/pop
//   head_nxt_c       head word after this cycle's push/pop (bypasses a push into an empty FIFO)
//   full_c, empty_c  decoded from count
module sfifo_fwft_w32 #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       rd_en,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt_c,
  output logic [31:0]                head_nxt_c,
  output logic                       full_c,
  output logic                       empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nxt;
  logic          wr_ok;
  logic          rd_ok;
  logic [CW-1:0] count_after_pop;

  assign full_c          = (count == CW'(DEPTH));
  assign empty_c         = (count == '0);
  assign wr_ok           = wr_en && !full_c;
  assign rd_ok           = rd_en && !empty_c;
  assign rptr_nxt        = rptr + AW'(rd_ok);
  assign count_after_pop = count - CW'(rd_ok);
  assign count_nxt_c     = count_after_pop + CW'(wr_ok);

  // A push landing in a FIFO that is empty after the pop becomes the head directly
  assign head_nxt_c = (wr_ok && (count_after_pop == '0)) ? wr_data : mem[rptr_nxt];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  // Pointers wrap mod DEPTH; the extra count bit separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_ok);
      rptr  <= rptr_nxt;
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/audio_rd_burst_fifo.sv
// Playback read burst FIFO: requests fixed-length read bursts from the memory
// controller, buffers returned 32-bit words and unpacks each into two PCM
// samples (low half first) on a registered valid/ready stream.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   enable                      playback enable, gates new burst requests
//   burst_req / burst_ack       one BL-word read burst request / 1-cycle accept
//   burst_wr_en, burst_wr_data  returned word beats ([DSIZE-1:32] ignored)
//   pcm_vld_o, pcm_rdy_i, pcm_data_o  PCM sample stream
//   level_o                     stored words
//   err_bfifo_ovf, err_underrun sticky error flags
// Macros:
//   AUDIO_RD_ZERO_FILL_EN  present silence samples while primed and starved
//   SIM_ENABLE             report and stop on a newly set error flag
module audio_rd_burst_fifo
  import audio_rd_burst_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned BL    = MEM_RD_BL,
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned PCM_W = PCM_DSIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic                    burst_req,
  input  logic                    burst_ack,
  input  logic                    burst_wr_en,
  input  logic [DSIZE-1:0]        burst_wr_data,
  output logic                    pcm_vld_o,
  input  logic                    pcm_rdy_i,
  output logic [PCM_W-1:0]        pcm_data_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    err_bfifo_ovf,
  output logic                    err_underrun
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(BL + 1);

  burst_state_t   state;
  burst_state_t   state_nxt;
  logic [BW-1:0]  beat;
  logic [BW-1:0]  beat_nxt;
  logic           half;
  logic           half_nxt;
  logic           primed;
  logic           primed_nxt;
  logic           burst_req_nxt;
  logic           vld_nxt;
  logic [PCM_W-1:0] data_nxt;
  logic           ovf_nxt;
  logic           und_nxt;

  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic [31:0]    head_nxt;
  logic           full;
  logic           empty;
  logic           wr;
  logic           take;
  logic           pop;
  logic           room;
  pcm_pair_t      head_pair;
  logic           unused_hi;

  assign unused_hi = ^burst_wr_data[DSIZE-1:WORD_W];

  // Only real stored samples advance the unpacker; inserted silence does not
  assign take      = pcm_vld_o && pcm_rdy_i && !empty;
  assign pop       = take && half;
  assign wr        = burst_wr_en && (state == XFER) && !full;
  assign room      = (count <= CW'(DEPTH - BL));
  assign head_pair = pcm_pair_t'(head_nxt);

  sfifo_fwft_w32 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr),
    .wr_data     (burst_wr_data[WORD_W-1:0]),
    .rd_en       (pop),
    .count       (count),
    .count_nxt_c (count_nxt),
    .head_nxt_c  (head_nxt),
    .full_c      (full),
    .empty_c     (empty)
  );

  // Burst FSM, unpacker and error next-state
  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    half_nxt      = half;
    primed_nxt    = primed;
    burst_req_nxt = 1'b0;
    vld_nxt       = 1'b0;
    data_nxt      = '0;
    ovf_nxt       = err_bfifo_ovf;
    und_nxt       = err_underrun;

    case (state)
      IDLE: begin
        // Space is reserved up front since only one burst is ever outstanding
        if (enable && room) state_nxt = REQ;
      end
      REQ: begin
        if (burst_ack) begin
          state_nxt = XFER;
          beat_nxt  = '0;
        end
      end
      XFER: begin
        if (burst_wr_en) begin
          if (beat == BW'(BL - 1)) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    burst_req_nxt = (state_nxt == REQ);

    if (take) half_nxt = ~half;
    primed_nxt = enable && (primed || take);

    // Output registers track the post-update head so there is no bubble between words
    vld_nxt = (count_nxt != '0);
    if (vld_nxt) data_nxt = half_nxt ? PCM_W'(head_pair.hi) : PCM_W'(head_pair.lo);
`ifdef AUDIO_RD_ZERO_FILL_EN
    if (!vld_nxt && primed_nxt && enable) vld_nxt = 1'b1;
`endif

    if (burst_wr_en && ((state != XFER) || full)) ovf_nxt = 1'b1;
    if (primed && enable && pcm_rdy_i && empty)   und_nxt = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat          <= '0;
      half          <= 1'b0;
      primed        <= 1'b0;
      burst_req     <= 1'b0;
      pcm_vld_o     <= 1'b0;
      pcm_data_o    <= '0;
      level_o       <= '0;
      err_bfifo_ovf <= 1'b0;
      err_underrun  <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat          <= beat_nxt;
      half          <= half_nxt;
      primed        <= primed_nxt;
      burst_req     <= burst_req_nxt;
      pcm_vld_o     <= vld_nxt;
      pcm_data_o    <= data_nxt;
      level_o       <= count_nxt;
      err_bfifo_ovf <= ovf_nxt;
      err_underrun  <= und_nxt;
    end
  end

`ifdef SIM_ENABLE
  // Simulation-only trap on a newly raised error
  always @(posedge clk) begin
    if (rst_n && ((ovf_nxt && !err_bfifo_ovf) || (und_nxt && !err_underrun))) begin
      $display("audio_rd_burst_fifo: error raised ovf=%0b underrun=%0b", ovf_nxt, und_nxt);
      $stop;
    end
  end
`endif

endmodule

// File: tb/tb_audio_rd_burst_fifo.sv
// Scoreboard bench for audio_rd_burst_fifo: the memory-side driver pushes the
// expected PCM samples of every returned word; a negedge monitor pops and
// compares on each valid/ready handshake.
module tb_audio_rd_burst_fifo;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned BL    = 16;
  localparam int unsigned DSIZE = 36;
  localparam int unsigned PCM_W = 16;
  localparam int unsigned LW    = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              burst_ack = 1'b0;
  logic              burst_wr_en = 1'b0;
  logic [DSIZE-1:0]  burst_wr_data = '0;
  logic              pcm_rdy_i = 1'b0;
  logic              burst_req;
  logic              pcm_vld_o;
  logic [PCM_W-1:0]  pcm_data_o;
  logic [LW-1:0]     level_o;
  logic              err_bfifo_ovf;
  logic              err_underrun;

  int          n_vec = 0;
  int          n_err = 0;
  int          word_k = 0;
  logic [15:0] exp_q[$];

  audio_rd_burst_fifo #(
    .DEPTH (DEPTH),
    .BL    (BL),
    .DSIZE (DSIZE),
    .PCM_W (PCM_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .burst_req     (burst_req),
    .burst_ack     (burst_ack),
    .burst_wr_en   (burst_wr_en),
    .burst_wr_data (burst_wr_data),
    .pcm_vld_o     (pcm_vld_o),
    .pcm_rdy_i     (pcm_rdy_i),
    .pcm_data_o    (pcm_data_o),
    .level_o       (level_o),
    .err_bfifo_ovf (err_bfifo_ovf),
    .err_underrun  (err_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens at the next posedge
  always @(negedge clk) begin
    if (rst_n && pcm_vld_o && pcm_rdy_i) begin
      if (exp_q.size() != 0) begin
        check("pcm_data", 32'(pcm_data_o), 32'(exp_q.pop_front()));
      end
`ifdef AUDIO_RD_ZERO_FILL_EN
      else if (pcm_data_o == '0) begin
      end
`endif
      else begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_sample: got 0x%0h expected none", pcm_data_o);
      end
    end
  end

  task automatic reset_dut();
    rst_n       = 1'b0;
    enable      = 1'b0;
    burst_ack   = 1'b0;
    burst_wr_en = 1'b0;
    pcm_rdy_i   = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Memory controller model: wait for a request, ack after ack_dly clocks, return n_words
  task automatic do_burst(input int ack_dly, input bit chk_req, input int n_words, input bit push);
    int t;
    logic [15:0] lo;
    logic [15:0] hi;
    t = 0;
    while (burst_req !== 1'b1 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (burst_req !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_req_timeout: got 0 expected 1");
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk); #1;
      if (chk_req) check("req_held", 32'(burst_req), 32'd1);
    end
    burst_ack = 1'b1;
    @(posedge clk); #1;
    burst_ack = 1'b0;
    if (chk_req) check("req_drop", 32'(burst_req), 32'd0);
    for (int i = 0; i < n_words; i++) begin
      lo = 16'(2 * word_k + 1);
      hi = 16'(2 * word_k + 2);
      word_k++;
      burst_wr_data = {4'hA, hi, lo};
      burst_wr_en   = 1'b1;
      if (push) begin
        exp_q.push_back(lo);
        exp_q.push_back(hi);
      end
      @(posedge clk); #1;
    end
    burst_wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    bit  any_req;
    bit  done;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_req",   32'(burst_req),     32'd0);
    check("rst_vld",   32'(pcm_vld_o),     32'd0);
    check("rst_data",  32'(pcm_data_o),    32'd0);
    check("rst_level", 32'(level_o),       32'd0);
    check("rst_ovf",   32'(err_bfifo_ovf), 32'd0);
    check("rst_und",   32'(err_underrun),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single burst 0x0002_0001..0x0020_001F, ack after 3 clocks
    word_k = 0;
    enable = 1'b1;
    do_burst(3, 1'b1, 16, 1'b1);
    @(posedge clk); #1;
    check("t1_level_peak", 32'(level_o),    32'd16);
    check("t1_head",       32'(pcm_data_o), 32'h0001);
    pcm_rdy_i = 1'b1;
    wait_drain("t1_drain", 200);
    @(posedge clk); #1;
    check("t1_level_end", 32'(level_o), 32'd0);

    // Fill to DEPTH with the consumer stalled: exactly 32 bursts
    reset_dut();
    enable = 1'b1;
    for (int b = 0; b < 32; b++) do_burst(1, 1'b0, 16, 1'b1);
    any_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      any_req |= burst_req;
    end
    check("t2_no_req_full", 32'(any_req),       32'd0);
    check("t2_level_full",  32'(level_o),       32'd512);
    check("t2_ovf",         32'(err_bfifo_ovf), 32'd0);
    check("t2_und",         32'(err_underrun),  32'd0);
    pcm_rdy_i = 1'b1;
    repeat (1024) @(posedge clk);
    #1;
    check("t2_no_bubble_level", 32'(level_o),      32'd0);
    check("t2_no_bubble_q",     32'(exp_q.size()), 32'd0);

    // Stray beat in IDLE is dropped and flagged
    reset_dut();
    pcm_rdy_i = 1'b1;
    @(posedge clk); #1;
    burst_wr_data = {4'h0, 32'hDEAD_BEEF};
    burst_wr_en   = 1'b1;
    @(posedge clk); #1;
    burst_wr_en = 1'b0;
    check("t3_ovf",   32'(err_bfifo_ovf), 32'd1);
    check("t3_level", 32'(level_o),       32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_vld",   32'(pcm_vld_o),     32'd0);
    check("t3_req",   32'(burst_req),     32'd0);
    check("t3_ovf_sticky", 32'(err_bfifo_ovf), 32'd1);

    // Underrun after priming
    reset_dut();
    enable    = 1'b1;
    pcm_rdy_i = 1'b1;
    do_burst(2, 1'b0, 16, 1'b1);
`ifdef AUDIO_RD_ZERO_FILL_EN
    wait_drain("t4_drain", 200);
    repeat (2) @(posedge clk);
    #1;
    check("t4_fill_vld",  32'(pcm_vld_o),    32'd1);
    check("t4_fill_data", 32'(pcm_data_o),   32'd0);
    check("t4_und",       32'(err_underrun), 32'd1);
`else
    t = 0;
    while (pcm_vld_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("t4_vld_low",  32'(pcm_vld_o),    32'd0);
    check("t4_q_empty",  32'(exp_q.size()), 32'd0);
    check("t4_und_pre",  32'(err_underrun), 32'd0);
    @(posedge clk); #1;
    check("t4_und",      32'(err_underrun), 32'd1);
`endif
    check("t4_ovf", 32'(err_bfifo_ovf), 32'd0);

    // Reset in the middle of a burst
    reset_dut();
    enable = 1'b1;
    do_burst(1, 1'b0, 7, 1'b0);
    check("t5_pre_vld", 32'(pcm_vld_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_req",   32'(burst_req),     32'd0);
    check("t5_vld",   32'(pcm_vld_o),     32'd0);
    check("t5_data",  32'(pcm_data_o),    32'd0);
    check("t5_level", 32'(level_o),       32'd0);
    check("t5_ovf",   32'(err_bfifo_ovf), 32'd0);
    check("t5_und",   32'(err_underrun),  32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    pcm_rdy_i = 1'b1;
    do_burst(1, 1'b0, 16, 1'b1);
    wait_drain("t5_drain", 200);

    // Random consumer stalls over 64 bursts
    reset_dut();
    enable = 1'b1;
    done   = 1'b0;
    fork
      begin
        for (int b = 0; b < 64; b++) do_burst(1, 1'b0, 16, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          pcm_rdy_i = 1'($urandom_range(0, 1));
        end
      end
    join
    enable    = 1'b0;
    pcm_rdy_i = 1'b1;
    wait_drain("t6_drain", 3000);
    check("t6_ovf", 32'(err_bfifo_ovf), 32'd0);
    check("t6_und", 32'(err_underrun),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_rd_burst_fifo.md
Name: audio_rd_burst_fifo

Overview:
- Playback-side counterpart of the audio write burst FIFO.
- Requests fixed-length read bursts from the memory controller and buffers the returned 32-bit words.
- Unpacks each word into two 16-bit PCM samples on a valid/ready stream toward the audio output path.
- Single clock domain (memory/controller clock); any CDC to the I2S domain lives downstream.

Parameters:
- DEPTH, 512, buffer depth in 32-bit words (power of two).
- BL, `MEM_RD_BL (16), words per memory read burst.
- DSIZE, `DSIZE (36), memory data width; only bits [31:0] are used.
- PCM_W, `PCM_DSIZE (16), PCM sample width.

Ports:
- clk            in   1      clock
- rst_n          in   1      async active-low reset
- enable         in   1      playback enable; gates new burst requests
- burst_req      out  1      request for one BL-word read burst
- burst_ack      in   1      controller accepted request (1-cycle pulse)
- burst_wr_en    in   1      returned word valid
- burst_wr_data  in   DSIZE  returned word; [DSIZE-1:32] ignored
- pcm_vld_o      out  1      PCM sample valid
- pcm_rdy_i      in   1      PCM sample ready
- pcm_data_o     out  PCM_W  PCM sample
- level_o        out  log2(DEPTH)+1  stored words
- err_bfifo_ovf  out  1      sticky: word arrived outside a burst or while full
- err_underrun   out  1      sticky: consumer starved after priming

Behaviour:
- Reset (rst_n low, async): burst_req=0, pcm_vld_o=0, pcm_data_o=0, level_o=0, both err flags=0, FSM=IDLE, pointers/half-select=0, primed=0.
- Storage: synchronous RAM/regs with read pointer, write pointer and a (log2(DEPTH)+1)-bit count; full = count==DEPTH; free = DEPTH-count.
- FSM:
  - IDLE -> REQ when enable && free >= BL; reserves space, since only one burst is ever outstanding.
  - REQ: burst_req=1 held until burst_ack; on ack -> XFER (burst_req deasserts the cycle after ack).
  - XFER: count burst_wr_en beats; after the BL-th beat -> IDLE.
  - Dropping enable does not abort REQ or XFER; it only blocks IDLE->REQ.
- Write: burst_wr_en in XFER and not full -> store [31:0], count+1.
- Error: burst_wr_en in IDLE/REQ, or while full -> word dropped, err_bfifo_ovf=1 until reset.
- Read/unpack, FWFT:
  - pcm_vld_o=1 when count>0, registered; a word written at cycle N is visible at N+1.
  - Sample order: half=0 presents word[15:0], half=1 presents word[31:16].
  - Handshake (vld&&rdy) toggles half; on the half=1 handshake the word is popped, count-1.
  - Pop and write in the same cycle leave count unchanged.
  - Sustained throughput is 1 sample/clk; there is no bubble between words when count>=2.
- level_o = count, registered each cycle.
- Underrun:
  - primed is set on the first handshake and cleared when enable=0.
  - If primed && enable && pcm_rdy_i && !pcm_vld_o, then err_underrun=1 (sticky).
- Wrap-around: pointers wrap mod DEPTH; count uses the extra bit to distinguish full from empty.

Optional Feature:
- Macro AUDIO_RD_ZERO_FILL_EN.
- Defined: when primed && enable && count==0, pcm_vld_o=1 with pcm_data_o=0, so silence is inserted. Inserted samples do not touch half-select or count. err_underrun still sets on the first inserted sample.
- Undefined: pcm_vld_o follows count only, and the consumer stalls.
- Under SIM_ENABLE, any error set issues $display and $stop.

Decomposition:
- Shared defines header: `MEM_RD_BL, `DSIZE, `PCM_DSIZE, plus localparam FSM encodings IDLE=2'd0, REQ=2'd1, XFER=2'd2.
- One natural sub-module, sfifo_fwft_w32 (single-clock FWFT FIFO with count). The parent holds the burst FSM and the 32->16 unpacker.

Test Plan:
- Reset, enable=1, ack after 3 clks, feed 16 words 0x0002_0001..0x0020_001F -> burst_req high until ack; pcm_data_o sequence 0x0001,0x0002,...,0x0020 with pcm_rdy_i=1; level_o peaks at 16.
- DEPTH=512, pcm_rdy_i=0, continuous acks -> exactly 32 bursts; burst_req stays 0 at level_o=512; no err flags.
- Extra burst_wr_en in IDLE with data 0xDEAD_BEEF -> err_bfifo_ovf=1; level_o unchanged; 0xBEEF never appears on pcm_data_o.
- After priming, stop acks and hold pcm_rdy_i=1 -> err_underrun=1 the cycle after the last sample. With AUDIO_RD_ZERO_FILL_EN: pcm_vld_o stays 1 with data 0x0000.
- Deassert rst_n in XFER after 7 of 16 beats -> all outputs at reset values immediately. After release with enable=1, a fresh burst_req appears and no stale samples are output.
- Randomised pcm_rdy_i (50%) over 64 bursts -> output order matches the scoreboard exactly; no errors.
